// File: rtl/arb_pkg.sv
// Shared types and sizing helpers for the round-robin push arbiter.
package arb_pkg;

  // Largest number of push heads the head-index type can address.
  localparam int unsigned MAX_HEADS = 4;

  // Index of a FIFO push head (0..MAX_HEADS-1).
  typedef logic [1:0] head_idx_t;

  // DL2 = log2 of the FIFO depth.
  function automatic int unsigned dl2(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Credit counter width: holds 0..DEPTH inclusive.
  function automatic int unsigned credit_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rr_push_arbiter_if.sv
// Requester and FIFO-push bundle for rr_push_arbiter.
//   req/req_data  : requester requests and their payloads
//   gnt           : one-cycle grant pulses back to requesters
//   push/dinp     : FIFO push strobes and data, one lane per head
//   ret_cnt       : entries popped from the FIFO this cycle
// master = arbiter side, slave = requester/FIFO side.
interface rr_push_arbiter_if
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned REQS  = 4,
  parameter int unsigned HEADS = 2,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CW = credit_w(DEPTH);

  logic [REQS-1:0]             req;
  logic [REQS-1:0][WIDTH-1:0]  req_data;
  logic [REQS-1:0]             gnt;
  logic [HEADS-1:0]            push;
  logic [HEADS-1:0][WIDTH-1:0] dinp;
  logic [CW-1:0]               ret_cnt;

  modport master (input req, req_data, ret_cnt, output gnt, push, dinp);
  modport slave  (output req, req_data, ret_cnt, input gnt, push, dinp);
endinterface

// File: rtl/rr_pick.sv
// Rotating-priority picker: grants the first up-to-k eligible requesters
// scanning from ptr, and reports which push head each grant maps to.
//   elig    : eligible requesters
//   ptr     : scan start index
//   k       : maximum number of grants
//   grant   : granted requesters
//   head    : head index per requester (valid where grant is set)
//   n_grant : number of grants
//   last    : index of the last granted requester
//   any     : at least one grant
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned REQS  = 4,
  parameter int unsigned HEADS = 2
) (
  input  logic [REQS-1:0]              elig,
  input  logic [$clog2(REQS)-1:0]      ptr,
  input  logic [$clog2(HEADS+1)-1:0]   k,
  output logic [REQS-1:0]              grant,
  output head_idx_t [REQS-1:0]         head,
  output logic [$clog2(HEADS+1)-1:0]   n_grant,
  output logic [$clog2(REQS)-1:0]      last,
  output logic                         any
);
  localparam int unsigned PW = $clog2(REQS);
  localparam int unsigned KW = $clog2(HEADS + 1);
  localparam int unsigned SW = PW + 1;

  logic [SW-1:0] sum;
  logic [PW-1:0] idx;

  // Walk ptr, ptr+1, ... mod REQS, granting while the limit allows.
  always_comb begin
    grant   = '0;
    head    = '0;
    n_grant = '0;
    last    = '0;
    any     = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int j = 0; j < REQS; j++) begin
      sum = {1'b0, ptr} + SW'(j);
      if (sum >= SW'(REQS)) sum = sum - SW'(REQS);
      idx = sum[PW-1:0];
      if (elig[idx] && (n_grant < k)) begin
        grant[idx] = 1'b1;
        head[idx]  = head_idx_t'(n_grant);
        last       = idx;
        any        = 1'b1;
        n_grant    = n_grant + KW'(1);
      end
    end
  end
endmodule

// File: rtl/rr_push_arbiter.sv
// Credit-limited round-robin arbiter feeding a multi-head FIFO push port.
//   clk, rst : clock; asynchronous active-low reset
//   en       : arbitration enable
//   bus      : requester req/req_data/gnt, FIFO push/dinp/ret_cnt
//   credit   : free FIFO entries as tracked here
//   ovf_err  : sticky credit overflow
module rr_push_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned REQS  = 4,
  parameter int unsigned HEADS = 2,
  parameter int unsigned DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  rr_push_arbiter_if.master           bus,
  output logic [credit_w(DEPTH)-1:0]  credit,
  output logic                        ovf_err
);
  localparam int unsigned DL2 = dl2(DEPTH);
  localparam int unsigned CW  = DL2 + 1;
  localparam int unsigned XW  = DL2 + 2;
  localparam int unsigned PW  = $clog2(REQS);
  localparam int unsigned KW  = $clog2(HEADS + 1);

  // Elaboration-time parameter checks.
  if ((DEPTH == 0) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("rr_push_arbiter: DEPTH must be a power of 2");
  end
  if ((REQS < 2) || (REQS > 16)) begin : g_reqs_chk
    $error("rr_push_arbiter: REQS must be 2..16");
  end
  if ((HEADS < 1) || (HEADS > MAX_HEADS) || (HEADS > REQS)) begin : g_heads_chk
    $error("rr_push_arbiter: HEADS must be 1..4 and <= REQS");
  end

  logic [PW-1:0]               rr_ptr, rr_ptr_d;
  logic [REQS-1:0]             elig;
  logic [KW-1:0]               k;
  logic [REQS-1:0]             pick_grant;
  head_idx_t [REQS-1:0]        pick_head;
  logic [KW-1:0]               n_grant;
  logic [PW-1:0]               last;
  logic                        any;
  logic [REQS-1:0]             gnt_d;
  logic [HEADS-1:0]            push_d;
  logic [HEADS-1:0][WIDTH-1:0] dinp_d;
  logic [XW-1:0]               credit_x;
  logic [CW-1:0]               credit_d;
  logic                        ovf_d;

  // Outstanding grants are masked so a requester is not granted twice.
  assign elig = bus.req & ~bus.gnt & {REQS{en}};

  // Grant limit from current credit only; same-cycle returns do not count.
  always_comb begin
    k = KW'(HEADS);
    if (credit < CW'(HEADS)) k = KW'(credit);
  end

  rr_pick #(.REQS(REQS), .HEADS(HEADS)) u_pick (
    .elig    (elig),
    .ptr     (rr_ptr),
    .k       (k),
    .grant   (pick_grant),
    .head    (pick_head),
    .n_grant (n_grant),
    .last    (last),
    .any     (any)
  );

  // Next-state: route granted data to heads, pointer, credit accounting.
  always_comb begin
    gnt_d    = pick_grant;
    push_d   = '0;
    dinp_d   = '0;
    rr_ptr_d = rr_ptr;
    ovf_d    = ovf_err;
    for (int h = 0; h < HEADS; h++) begin
      for (int i = 0; i < REQS; i++) begin
        if (pick_grant[i] && (pick_head[i] == head_idx_t'(h))) begin
          push_d[h] = 1'b1;
          dinp_d[h] = bus.req_data[i];
        end
      end
    end
    if (any) rr_ptr_d = (last == PW'(REQS - 1)) ? '0 : last + PW'(1);
    // n_grant never exceeds credit, so the subtraction cannot underflow.
    credit_x = XW'(credit) - XW'(n_grant) + XW'(bus.ret_cnt);
    if (credit_x > XW'(DEPTH)) begin
      credit_d = CW'(DEPTH);
      ovf_d    = 1'b1;
    end else begin
      credit_d = credit_x[CW-1:0];
    end
  end

  // State registers; reset discards any pending grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.gnt  <= '0;
      bus.push <= '0;
      bus.dinp <= '0;
      rr_ptr   <= '0;
      credit   <= CW'(DEPTH);
      ovf_err  <= 1'b0;
    end else begin
      bus.gnt  <= gnt_d;
      bus.push <= push_d;
      bus.dinp <= dinp_d;
      rr_ptr   <= rr_ptr_d;
      credit   <= credit_d;
      ovf_err  <= ovf_d;
    end
  end
endmodule

// File: tb/tb_rr_push_arbiter.sv
// Directed bench for rr_push_arbiter (REQS=4, HEADS=2, DEPTH=16).
module tb_rr_push_arbiter;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned REQS  = 4;
  localparam int unsigned HEADS = 2;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [4:0] credit;
  logic       ovf_err;

  int n_chk  = 0;
  int n_fail = 0;

  rr_push_arbiter_if #(.WIDTH(WIDTH), .REQS(REQS), .HEADS(HEADS), .DEPTH(DEPTH)) bus ();

  rr_push_arbiter #(.WIDTH(WIDTH), .REQS(REQS), .HEADS(HEADS), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .bus     (bus),
    .credit  (credit),
    .ovf_err (ovf_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check every observable output against hand-computed values.
  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] p,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [4:0] c, input logic ov);
    check({tag, "_gnt"},    64'(bus.gnt),     64'(g));
    check({tag, "_push"},   64'(bus.push),    64'(p));
    check({tag, "_dinp0"},  64'(bus.dinp[0]), 64'(d0));
    check({tag, "_dinp1"},  64'(bus.dinp[1]), 64'(d1));
    check({tag, "_credit"}, 64'(credit),      64'(c));
    check({tag, "_ovf"},    64'(ovf_err),     64'(ov));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    bus.req     = '0;
    bus.ret_cnt = '0;
    for (int i = 0; i < REQS; i++) bus.req_data[i] = dat(i);
    tick();
    chk_out("reset", 4'b0000, 2'b00, 32'h0, 32'h0, 5'd16, 1'b0);

    // All requesters continuously active: pairs alternate, credit falls by 2.
    rst = 1'b1; en = 1'b1; bus.req = 4'b1111;
    tick(); chk_out("all_p1", 4'b0011, 2'b11, dat(0), dat(1), 5'd14, 1'b0);
    tick(); chk_out("all_p2", 4'b1100, 2'b11, dat(2), dat(3), 5'd12, 1'b0);
    tick(); chk_out("all_p3", 4'b0011, 2'b11, dat(0), dat(1), 5'd10, 1'b0);
    tick(); chk_out("all_p4", 4'b1100, 2'b11, dat(2), dat(3), 5'd8,  1'b0);
    tick(); chk_out("all_p5", 4'b0011, 2'b11, dat(0), dat(1), 5'd6,  1'b0);
    tick(); chk_out("all_p6", 4'b1100, 2'b11, dat(2), dat(3), 5'd4,  1'b0);
    tick(); chk_out("all_p7", 4'b0011, 2'b11, dat(0), dat(1), 5'd2,  1'b0);
    tick(); chk_out("all_p8", 4'b1100, 2'b11, dat(2), dat(3), 5'd0,  1'b0);
    // Credit exhausted: nothing granted.
    tick(); chk_out("cred0", 4'b0000, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0);

    // Return at zero credit only takes effect next cycle.
    bus.req = 4'b0111; bus.ret_cnt = 5'd1;
    tick(); chk_out("cred0_ret", 4'b0000, 2'b00, 32'h0, 32'h0, 5'd1, 1'b0);
    // credit=1 with three requesters: one grant, return of 2 applied together.
    bus.ret_cnt = 5'd2;
    tick(); chk_out("cred1", 4'b0001, 2'b01, dat(0), 32'h0, 5'd2, 1'b0);
    bus.ret_cnt = 5'd0;
    tick(); chk_out("cred2", 4'b0110, 2'b11, dat(1), dat(2), 5'd0, 1'b0);

    // Lone requester 3 (rr_ptr=3) waits for credit, then maps to head 0.
    bus.req = 4'b1000; bus.ret_cnt = 5'd4;
    tick(); chk_out("r3_wait", 4'b0000, 2'b00, 32'h0, 32'h0, 5'd4, 1'b0);
    bus.ret_cnt = 5'd0;
    tick(); chk_out("r3_gnt", 4'b1000, 2'b01, dat(3), 32'h0, 5'd3, 1'b0);
    tick(); chk_out("r3_noregrant", 4'b0000, 2'b00, 32'h0, 32'h0, 5'd3, 1'b0);

    // Wrapped pointer is 0; decision then en drops: push completes, no more grants.
    bus.req = 4'b0011;
    tick(); chk_out("en_pend", 4'b0011, 2'b11, dat(0), dat(1), 5'd1, 1'b0);
    en = 1'b0; bus.ret_cnt = 5'd3;
    tick(); chk_out("en_off", 4'b0000, 2'b00, 32'h0, 32'h0, 5'd4, 1'b0);

    // Fill credit back to DEPTH, then overflow by one.
    bus.ret_cnt = 5'd12;
    tick(); chk_out("full", 4'b0000, 2'b00, 32'h0, 32'h0, 5'd16, 1'b0);
    bus.ret_cnt = 5'd1;
    tick(); chk_out("ovf", 4'b0000, 2'b00, 32'h0, 32'h0, 5'd16, 1'b1);
    bus.ret_cnt = 5'd0;
    tick(); chk_out("ovf_hold", 4'b0000, 2'b00, 32'h0, 32'h0, 5'd16, 1'b1);

    // rr_ptr=2: scan 2,3,0 grants 2 then 0; ovf stays set.
    en = 1'b1; bus.req = 4'b0111;
    tick(); chk_out("scan2", 4'b0101, 2'b11, dat(2), dat(0), 5'd14, 1'b1);

    // Asynchronous reset between edges clears everything immediately.
    #3 rst = 1'b0;
    #1 chk_out("async_rst", 4'b0000, 2'b00, 32'h0, 32'h0, 5'd16, 1'b0);
    tick(); chk_out("rst_hold", 4'b0000, 2'b00, 32'h0, 32'h0, 5'd16, 1'b0);

    // After release rr_ptr is 0: requester 0 on head 0, requester 3 on head 1.
    rst = 1'b1; bus.req = 4'b1001;
    tick(); chk_out("post_rst", 4'b1001, 2'b11, dat(0), dat(3), 5'd14, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_push_arbiter.md
RR_PUSH_ARBITER -- requirements
Module: rr_push_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- WIDTH, 32: data bits per entry.
- REQS, 4: number of requesters (2..16).
- HEADS, 2: number of FIFO push ports served (1..4, HEADS <= REQS).
- DEPTH, 16: depth of the downstream FIFO (power of 2; non-power elaboration SHALL $error).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: reset; one clock; reset is asynchronous and active-low.
- en, in, 1: arbitration enable.
- req, in, REQS: per-requester request; held high until its gnt is seen.
- req_data, in, REQS x WIDTH: per-requester data; stable while req is high.
- gnt, out, REQS: one-cycle grant pulse, registered.
- push, out, HEADS: FIFO push strobes, registered.
- dinp, out, HEADS x WIDTH: FIFO push data, registered.
- ret_cnt, in, $clog2(DEPTH)+1: entries popped from the FIFO this cycle.
- credit, out, $clog2(DEPTH)+1: free FIFO entries as tracked by the arbiter.
- ovf_err, out, 1: sticky credit-overflow error.

Function
REQ-003 Requester i SHALL be eligible in cycle t iff en=1, req[i]=1 and gnt[i]=0 in cycle t; the gnt mask prevents a double grant while the requester drops req.
REQ-004 Grant limit K SHALL be min(HEADS, credit) using the current credit; ret_cnt of the same cycle SHALL NOT raise K.
REQ-005 Scan order SHALL be rr_ptr, rr_ptr+1, ... mod REQS.
REQ-006 The first up-to-K eligible requesters in scan order SHALL be granted.
REQ-007 The n-th granted requester SHALL map to push head n (n = 0..K-1).
REQ-008 Unused heads SHALL have push=0 and dinp=0.
REQ-009 Latency SHALL be one cycle: a decision in cycle t drives gnt, push and dinp (req_data sampled at t) in cycle t+1.
REQ-010 rr_ptr SHALL update to (index of the last granted requester + 1) mod REQS, and SHALL hold when nothing is granted.
REQ-011 The credit update SHALL be credit_next = credit - grants_issued + ret_cnt, computed at width $clog2(DEPTH)+2.
REQ-012 If credit_next > DEPTH, credit SHALL saturate at DEPTH and ovf_err SHALL set and hold until reset.
REQ-013 At credit=0 no grants SHALL issue; a same-cycle ret_cnt SHALL take effect in the next cycle.
REQ-014 With en=0 no new grants SHALL issue, grants already decided SHALL still complete the next cycle, and credit SHALL keep accounting ret_cnt.
REQ-015 Simultaneous grant and return SHALL both be applied in the same update.
REQ-016 rr_ptr wrap from REQS-1 to 0 SHALL occur with no skipped requester.

Reset
REQ-017 On rst=0, regardless of clk, the block SHALL reset asynchronously:
- gnt, push, dinp = 0; ovf_err = 0; rr_ptr = 0.
- credit = DEPTH.
REQ-018 While rst=0, no outputs SHALL change.
REQ-019 Release SHALL be synchronous to clk; the first arbitration is in the first clk edge with rst=1.
REQ-020 A reset mid-operation SHALL discard the pending registered grants; no push SHALL appear after assertion.

Structure
REQ-021 Package arb_pkg SHALL hold the credit width function/localparam (DL2 = $clog2(DEPTH)) and a typedef for the head-index type.
REQ-022 The rotate-priority selection SHALL be a sub-module rr_pick (REQS bits in, rr_ptr in, K in, grant vector plus head mapping out), purely combinational.
REQ-023 All state SHALL be in rr_push_arbiter.
REQ-024 Total RTL SHALL be 120-400 lines.

Verification
REQ-025 REQS=4, HEADS=2, DEPTH=16; all req=1 continuously after reset -> grants alternate {0,1} and {2,3} on pairs of cycles, rr_ptr wraps 0->2->0, and credit falls by 2 per grant cycle.
REQ-026 Only req[3]=1, rr_ptr=2 -> gnt[3] one cycle later on push[0], rr_ptr=0, and no regrant while gnt[3]=1.
REQ-027 credit=1 with 3 requesters -> exactly one grant; ret_cnt=2 in the same cycle -> credit=2 next cycle, and two grants follow.
REQ-028 credit=DEPTH, ret_cnt=1 -> credit stays 16, ovf_err=1 and remains 1 until rst=0.
REQ-029 en=0 the cycle after a decision -> the pending push completes and no further gnt appears.
REQ-030 rst=0 asserted mid-cycle between edges -> push, gnt = 0 immediately and credit = 16.
